matrix_instr_sequencer: RTL

MATRIX_INSTR_SEQUENCER -- requirements
Module: matrix_instr_sequencer

---
 rtl/matrix_instr_sequencer.sv | 84 ++++++++
 1 files changed

// File: rtl/matrix_instr_sequencer.sv
// matrix_instr_sequencer: fetches, latches and issues instructions to a matrix datapath until HALT or end of program
// Ports:
//   CLK, RST (async, active-high)   St        start pulse, taken only in IDLE
//   instr_addr / instr_data          instruction memory (data valid one cycle after address)
//   issue_valid / issue_ready / issue_instr   handshake towards the datapath
//   exec_done, jump, jump_addr       retire pulse and optional branch from the datapath
//   busy, done, instr_cnt            run status, end-of-run pulse, retired instruction count
//   cycle_cnt                        busy-cycle counter, present only with SEQ_PERF_CNT_EN defined
module matrix_instr_sequencer #(
  parameter int INSTR_BIT = 4,
  parameter int INSTR_W   = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 St,
  input  logic                 jump,
  input  logic [INSTR_BIT-1:0] jump_addr,
  output logic [INSTR_BIT-1:0] instr_addr,
  input  logic [INSTR_W-1:0]   instr_data,
  output logic                 issue_valid,
  input  logic                 issue_ready,
  output logic [INSTR_W-1:0]   issue_instr,
  input  logic                 exec_done,
  output logic                 busy,
  output logic                 done,
  output logic [INSTR_BIT:0]   instr_cnt
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0]          cycle_cnt
`endif
);
  typedef enum logic [2:0] {IDLE, FETCH, LATCH, ISSUE, WAIT, FIN} state_t;
  localparam logic [INSTR_BIT-1:0] PC_LAST = '1;
  state_t state, state_nxt;
  logic [INSTR_BIT-1:0] pc;
  logic halt, start, retire;
  assign halt   = instr_data[INSTR_W-1 -: 4] == 4'hF;
  assign start  = state == IDLE && St;
  assign retire = state == WAIT && exec_done;
  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = St ? FETCH : IDLE;
      FETCH:   state_nxt = LATCH;
      LATCH:   state_nxt = halt ? FIN : ISSUE;
      ISSUE:   state_nxt = issue_ready ? WAIT : ISSUE;
      WAIT:    state_nxt = !exec_done ? WAIT : (!jump && pc == PC_LAST) ? FIN : FETCH;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    issue_valid = state == ISSUE;
    busy        = state != IDLE;
    done        = state == FIN;
    instr_addr  = pc;
  end
  // Retiring the last word without a branch ends the run; PC is held there rather than wrapping to 0.
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      pc          <= '0;
      instr_cnt   <= '0;
      issue_instr <= '0;
    end else begin
      if (start) begin
        pc        <= '0;
        instr_cnt <= '0;
      end
      if (state == LATCH) issue_instr <= instr_data;
      if (retire) begin
        instr_cnt <= instr_cnt + 1'b1;
        pc        <= jump ? jump_addr : (pc == PC_LAST) ? pc : pc + 1'b1;
      end
    end
`ifdef SEQ_PERF_CNT_EN
  always_ff @(posedge CLK or posedge RST)
    if (RST) cycle_cnt <= '0;
    else if (start) cycle_cnt <= '0;
    else if (busy && cycle_cnt != '1) cycle_cnt <= cycle_cnt + 1'b1;
`endif
endmodule
